// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: shadowed receiver config with busy-safe apply, oversample divider and 4-deep receive FIFO.
module uart_rx_ctrl #(
    parameter int DIV_LO = 326,
    parameter int DIV_HI = 27,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic       cfg_dnum,
    input  logic       cfg_snum,
    input  logic       cfg_bd_rate,
    input  logic       cfg_par,
    input  logic       rx_busy,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic [2:0] rx_err,
    output logic       dnum,
    output logic       snum,
    output logic       bd_rate,
    output logic       par,
    output logic       os_tick,
    output logic       host_valid,
    input  logic       host_ready,
    output logic [7:0] host_data,
    output logic [2:0] host_err,
    output logic [2:0] fifo_count,
    output logic       ovr_flag,
    input  logic       ovr_clr
);
    typedef enum logic {APPLIED, PENDING} state_t;
    localparam logic [2:0] FULL = 3'(DEPTH);
    state_t      state_q, state_d;
    logic [3:0]  sh_q, sh_d, app_q, app_d, cfg_in;
    logic [8:0]  cnt_q, cnt_d, div_m1;
    logic [1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [2:0]  count_q, count_d;
    logic        ovr_q, ovr_d, mark_q, mark_d;
    logic        apply, push, pop, drop;
    logic [10:0] mem_q [DEPTH];
    logic [10:0] mem_d [DEPTH];
    assign cfg_in = {cfg_dnum, cfg_snum, cfg_bd_rate, cfg_par};
    assign {dnum, snum, bd_rate, par} = app_q;
    assign div_m1 = app_q[1] ? 9'(DIV_HI - 1) : 9'(DIV_LO - 1);
    assign os_tick = cnt_q == div_m1;
    assign host_valid = count_q != 3'd0;
    assign host_data = host_valid ? mem_q[rp_q][7:0] : 8'd0;
    assign host_err = host_valid ? mem_q[rp_q][10:8] : 3'd0;
    assign fifo_count = count_q;
    assign ovr_flag = ovr_q;
    // A write that lands in the same cycle the receiver goes idle is the one applied.
    always_comb begin
        state_d = state_q;
        sh_d = cfg_wr ? cfg_in : sh_q;
        app_d = app_q;
        apply = 1'b0;
        if (state_q == APPLIED) begin
            if (cfg_wr && rx_busy) state_d = PENDING;
            else if (cfg_wr) begin
                app_d = cfg_in;
                apply = 1'b1;
            end
        end else if (!rx_busy) begin
            app_d = sh_d;
            apply = 1'b1;
            state_d = APPLIED;
        end
        cnt_d = (apply || os_tick) ? 9'd0 : cnt_q + 9'd1;
    end
    // When full, a same-cycle pop frees the head slot, which is exactly where wp points.
    always_comb begin
        pop = host_valid && host_ready;
        push = rx_done && (count_q != FULL || pop);
        drop = rx_done && !push;
        wp_d = wp_q + 2'(push);
        rp_d = rp_q + 2'(pop);
        count_d = count_q + 3'(push) - 3'(pop);
        ovr_d = drop ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
        mark_d = drop ? 1'b1 : push ? 1'b0 : mark_q;
        mem_d = mem_q;
        if (push) mem_d[wp_q] = {rx_err[2], rx_err[1] | mark_q, rx_err[0], rx_data};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= APPLIED;
            sh_q <= 4'd0;
            app_q <= 4'd0;
            cnt_q <= 9'd0;
            wp_q <= 2'd0;
            rp_q <= 2'd0;
            count_q <= 3'd0;
            ovr_q <= 1'b0;
            mark_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q <= sh_d;
            app_q <= app_d;
            cnt_q <= cnt_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            count_q <= count_d;
            ovr_q <= ovr_d;
            mark_q <= mark_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench with a queue scoreboard for the receive FIFO.
module tb_uart_rx_ctrl;
    logic       clk, rst, cfg_wr, cfg_dnum, cfg_snum, cfg_bd_rate, cfg_par;
    logic       rx_busy, rx_done, host_ready, ovr_clr;
    logic [7:0] rx_data, host_data;
    logic [2:0] rx_err, host_err, fifo_count;
    logic       dnum, snum, bd_rate, par, os_tick, host_valid, ovr_flag;
    int         checks = 0, failures = 0;
    logic [10:0] q[$];
    bit         mmark = 0, movr = 0;

    uart_rx_ctrl dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_dnum(cfg_dnum), .cfg_snum(cfg_snum),
        .cfg_bd_rate(cfg_bd_rate), .cfg_par(cfg_par), .rx_busy(rx_busy), .rx_done(rx_done),
        .rx_data(rx_data), .rx_err(rx_err), .dnum(dnum), .snum(snum), .bd_rate(bd_rate),
        .par(par), .os_tick(os_tick), .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_err(host_err), .fifo_count(fifo_count),
        .ovr_flag(ovr_flag), .ovr_clr(ovr_clr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clock edges from now until the edge that samples os_tick high (counter starts at 0).
    task automatic tick_wait(output int n);
        n = 0;
        while (!os_tick && n < 1000) begin
            cyc();
            n++;
        end
        n = n + 1;
    endtask

    task automatic step(input bit p, input logic [7:0] d, input logic [2:0] e, input bit r, input bit c);
        logic [10:0] exp;
        bit pop_m, push_m;
        rx_done = p; rx_data = d; rx_err = e; host_ready = r; ovr_clr = c;
        chk("host_valid", host_valid, q.size() != 0);
        pop_m = r && q.size() > 0;
        if (pop_m) begin
            exp = q.pop_front();
            chk("head", {host_err, host_data}, exp);
        end
        push_m = p && q.size() < 4;
        if (push_m) begin
            q.push_back({e[2], e[1] | mmark, e[0], d});
            mmark = 0;
        end
        if (p && !push_m) begin
            mmark = 1;
            movr = 1;
        end else if (c) movr = 0;
        cyc();
        rx_done = 0; host_ready = 0; ovr_clr = 0;
        chk("fifo_count", fifo_count, q.size());
        chk("ovr_flag", ovr_flag, movr);
    endtask

    initial begin
        int n;
        bit held;
        rst = 0; cfg_wr = 0; cfg_dnum = 0; cfg_snum = 0; cfg_bd_rate = 0; cfg_par = 0;
        rx_busy = 0; rx_done = 0; rx_data = 0; rx_err = 0; host_ready = 0; ovr_clr = 0;
        repeat (3) cyc();
        chk("rst_cfg", {dnum, snum, bd_rate, par}, 0);
        chk("rst_tick", os_tick, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", host_valid, 0);
        chk("rst_head", {host_err, host_data}, 0);
        chk("rst_ovr", ovr_flag, 0);
        rst = 1;
        tick_wait(n);
        chk("first_tick_lo", n, 326);
        cyc(); tick_wait(n);
        chk("period_lo", n, 326);
        cyc(); tick_wait(n);
        chk("period_lo2", n, 326);

        // Config written mid-frame waits for the receiver to go idle.
        cfg_dnum = 1; cfg_bd_rate = 1; cfg_wr = 1; rx_busy = 1;
        cyc();
        cfg_wr = 0;
        chk("pend_bd", bd_rate, 0);
        held = 1;
        repeat (49) begin
            cyc();
            held &= (bd_rate == 0) && (dnum == 0);
        end
        chk("pend_hold", held, 1);
        rx_busy = 0;
        chk("pend_idle_cycle", bd_rate, 0);
        cyc();
        chk("apply_cfg", {dnum, snum, bd_rate, par}, 4'b1010);
        tick_wait(n);
        chk("first_tick_hi", n, 27);
        cyc(); tick_wait(n);
        chk("period_hi", n, 27);
        cfg_par = 1; cfg_wr = 1;
        cyc();
        cfg_wr = 0;
        chk("direct_apply", {dnum, snum, bd_rate, par}, 4'b1011);
        tick_wait(n);
        chk("tick_after_apply", n, 27);

        // Fill, overflow, drain, and the overrun marker on the next accepted byte.
        step(0, 8'h00, 3'b000, 1, 0);
        step(1, 8'h11, 3'b000, 0, 0);
        step(1, 8'h22, 3'b001, 0, 0);
        step(1, 8'h33, 3'b100, 0, 0);
        step(1, 8'h44, 3'b000, 0, 0);
        step(1, 8'h55, 3'b000, 0, 0);
        repeat (4) step(0, 8'h00, 3'b000, 1, 0);
        step(1, 8'h66, 3'b000, 0, 0);
        step(0, 8'h00, 3'b000, 1, 0);
        step(0, 8'h00, 3'b000, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, 8'(8'hA0 + i), 3'(i), 0, 0);
        step(1, 8'hB5, 3'b000, 1, 0);
        step(1, 8'hD0, 3'b000, 0, 1);
        step(0, 8'h00, 3'b000, 0, 1);
        step(0, 8'h00, 3'b000, 1, 0);
        step(1, 8'hC1, 3'b101, 0, 0);
        step(1, 8'hC2, 3'b000, 0, 0);
        step(1, 8'hC3, 3'b000, 0, 0);
        repeat (2) step(0, 8'h00, 3'b000, 1, 0);
        step(1, 8'hD9, 3'b000, 0, 0);

        // Reset with a pending config and a non-empty FIFO.
        cfg_dnum = 0; cfg_snum = 1; cfg_wr = 1; rx_busy = 1;
        cyc();
        cfg_wr = 0;
        chk("pend_snum", snum, 0);
        chk("pre_rst_count", fifo_count, q.size());
        rst = 0;
        cyc();
        rst = 1;
        q.delete(); mmark = 0; movr = 0;
        chk("rst2_count", fifo_count, 0);
        chk("rst2_valid", host_valid, 0);
        chk("rst2_cfg", {dnum, snum, bd_rate, par}, 0);
        rx_busy = 0;
        cyc();
        chk("rst2_no_apply", {dnum, snum, bd_rate, par}, 0);
        step(1, 8'hE1, 3'b000, 0, 0);
        step(0, 8'h00, 3'b000, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
